// File: rtl/prescaled_updown_counter.sv
// General-purpose timed up/down counter driven by a programmable step prescaler.
// A single clock domain is used; the prescaler produces a one-cycle step enable.
module prescaled_updown_counter #(
  parameter int unsigned             WIDTH         = 4,
  parameter int unsigned             PRESCALE_BITS = 24,
  parameter logic [WIDTH-1:0]        RESET_VALUE   = {WIDTH{1'b1}}
) (
  input  logic                     mainClock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     up,
  input  logic                     saturate,
  input  logic                     load,
  input  logic [WIDTH-1:0]         loadValue,
  input  logic [PRESCALE_BITS-1:0] prescale,
  output logic [WIDTH-1:0]         count,
  output logic                     tick,
  output logic                     terminal,
  output logic [1:0]               state
);

  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE_VAL = WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HELD = 2'b10
  } state_e;

  state_e                   state_q, state_d;
  logic [WIDTH-1:0]         count_q, count_d;
  logic [PRESCALE_BITS-1:0] psc_q, psc_d;
  logic                     tick_q, tick_d;
  logic                     terminal_q, terminal_d;

  logic at_max, at_zero;
  assign at_max  = (count_q == MAX_VAL);
  assign at_zero = (count_q == '0);

  // State and output registers
  always_ff @(posedge mainClock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      count_q    <= RESET_VALUE;
      psc_q      <= '0;
      tick_q     <= 1'b0;
      terminal_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      psc_q      <= psc_d;
      tick_q     <= tick_d;
      terminal_q <= terminal_d;
    end
  end

  // Next-state: load > enable deassert > state-specific behaviour
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    psc_d      = psc_q;
    tick_d     = 1'b0;
    terminal_d = 1'b0;

    if (load) begin
      count_d = loadValue;
      psc_d   = '0;
      state_d = enable ? ST_RUN : ST_IDLE;
    end else if (!enable) begin
      psc_d   = '0;
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          psc_d   = '0;
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (psc_q >= prescale) begin
            psc_d = '0;
            if (up) begin
              if (!at_max) begin
                count_d    = count_q + ONE_VAL;
                tick_d     = 1'b1;
                terminal_d = saturate && (count_q == MAX_VAL - ONE_VAL);
              end else if (saturate) begin
                state_d = ST_HELD;
              end else begin
                count_d    = '0;
                tick_d     = 1'b1;
                terminal_d = 1'b1;
              end
            end else begin
              if (!at_zero) begin
                count_d    = count_q - ONE_VAL;
                tick_d     = 1'b1;
                terminal_d = saturate && (count_q == ONE_VAL);
              end else if (saturate) begin
                state_d = ST_HELD;
              end else begin
                count_d    = MAX_VAL;
                tick_d     = 1'b1;
                terminal_d = 1'b1;
              end
            end
          end else begin
            psc_d = psc_q + PRESCALE_BITS'(1);
          end
        end
        ST_HELD: begin
          // Leave the limit once direction points away from it or wrapping is allowed
          if ((!up && at_max) || (up && at_zero) || !saturate) begin
            psc_d   = '0;
            state_d = ST_RUN;
          end
        end
        default: begin
          psc_d   = '0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign count    = count_q;
  assign tick     = tick_q;
  assign terminal = terminal_q;
  assign state    = state_q;

endmodule

// File: tb/tb_prescaled_updown_counter.sv
// Directed self-checking bench for prescaled_updown_counter (WIDTH=4).
module tb_prescaled_updown_counter;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned PB    = 24;

  logic             mainClock = 1'b0;
  logic             reset, enable, up, saturate, load;
  logic [WIDTH-1:0] loadValue;
  logic [PB-1:0]    prescale;
  logic [WIDTH-1:0] count;
  logic             tick, terminal;
  logic [1:0]       state;

  int errors = 0;
  int checks = 0;

  prescaled_updown_counter #(.WIDTH(WIDTH), .PRESCALE_BITS(PB)) dut (
    .mainClock(mainClock), .reset(reset), .enable(enable), .up(up),
    .saturate(saturate), .load(load), .loadValue(loadValue),
    .prescale(prescale), .count(count), .tick(tick), .terminal(terminal),
    .state(state)
  );

  always #5 mainClock = ~mainClock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge mainClock);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] c, input logic t,
                            input logic term, input logic [1:0] st);
    check_eq({tag, ".count"}, 32'(count), 32'(c));
    check_eq({tag, ".tick"}, 32'(tick), 32'(t));
    check_eq({tag, ".terminal"}, 32'(terminal), 32'(term));
    check_eq({tag, ".state"}, 32'(state), 32'(st));
  endtask

  task automatic do_load(input logic [3:0] v);
    loadValue = v;
    load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  logic [3:0] exp_c [6];
  logic       exp_t [6];
  logic       exp_tm[6];

  initial begin
    reset = 1'b1; enable = 1'b0; up = 1'b1; saturate = 1'b0; load = 1'b0;
    loadValue = '0; prescale = '0;
    cyc(); cyc();
    expect_out("reset", 4'hF, 1'b0, 1'b0, 2'b00);

    // Up wrap, prescale=2
    reset = 1'b0; prescale = 24'd2; up = 1'b1; saturate = 1'b0; enable = 1'b1;
    do_load(4'hE);
    expect_out("upwrap.load", 4'hE, 1'b0, 1'b0, 2'b01);
    exp_c  = '{4'hE, 4'hE, 4'hF, 4'hF, 4'hF, 4'h0};
    exp_t  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_tm = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 6; k++) begin
      cyc();
      expect_out($sformatf("upwrap.c%0d", k + 1), exp_c[k], exp_t[k], exp_tm[k], 2'b01);
    end
    cyc();
    expect_out("upwrap.after", 4'h0, 1'b0, 1'b0, 2'b01);

    // Down saturate, prescale=0
    prescale = 24'd0; up = 1'b0; saturate = 1'b1;
    do_load(4'h2);
    expect_out("dsat.load", 4'h2, 1'b0, 1'b0, 2'b01);
    cyc(); expect_out("dsat.1", 4'h1, 1'b1, 1'b0, 2'b01);
    cyc(); expect_out("dsat.0", 4'h0, 1'b1, 1'b1, 2'b01);
    cyc(); expect_out("dsat.held", 4'h0, 1'b0, 1'b0, 2'b10);
    cyc(); expect_out("dsat.held2", 4'h0, 1'b0, 1'b0, 2'b10);
    up = 1'b1;
    cyc(); expect_out("dsat.rerun", 4'h0, 1'b0, 1'b0, 2'b01);
    cyc(); expect_out("dsat.step", 4'h1, 1'b1, 1'b0, 2'b01);

    // Up saturate at max, then release by clearing saturate
    do_load(4'hE);
    cyc(); expect_out("usat.max", 4'hF, 1'b1, 1'b1, 2'b01);
    cyc(); expect_out("usat.held", 4'hF, 1'b0, 1'b0, 2'b10);
    saturate = 1'b0;
    cyc(); expect_out("usat.rerun", 4'hF, 1'b0, 1'b0, 2'b01);
    cyc(); expect_out("usat.wrap", 4'h0, 1'b1, 1'b1, 2'b01);

    // Load mid-run at prescaler=3, prescale=5
    prescale = 24'd5;
    do_load(4'h3);
    for (int k = 0; k < 3; k++) cyc();
    expect_out("lmid.pre", 4'h3, 1'b0, 1'b0, 2'b01);
    do_load(4'h7);
    expect_out("lmid.load", 4'h7, 1'b0, 1'b0, 2'b01);
    for (int k = 0; k < 5; k++) begin
      cyc();
      expect_out($sformatf("lmid.wait%0d", k + 1), 4'h7, 1'b0, 1'b0, 2'b01);
    end
    cyc(); expect_out("lmid.step", 4'h8, 1'b1, 1'b0, 2'b01);

    // Prescale shrink below current prescaler value
    prescale = 24'd100;
    do_load(4'h0);
    for (int k = 0; k < 50; k++) cyc();
    expect_out("shrink.pre", 4'h0, 1'b0, 1'b0, 2'b01);
    prescale = 24'd10;
    cyc(); expect_out("shrink.force", 4'h1, 1'b1, 1'b0, 2'b01);
    for (int k = 0; k < 10; k++) cyc();
    expect_out("shrink.gap", 4'h1, 1'b0, 1'b0, 2'b01);
    cyc(); expect_out("shrink.next", 4'h2, 1'b1, 1'b0, 2'b01);

    // Enable drop on a step cycle, then reset while running
    prescale = 24'd2;
    do_load(4'h5);
    cyc(); cyc();
    enable = 1'b0;
    cyc(); expect_out("edrop.nostep", 4'h5, 1'b0, 1'b0, 2'b00);
    cyc(); expect_out("edrop.idle", 4'h5, 1'b0, 1'b0, 2'b00);
    enable = 1'b1;
    cyc(); expect_out("edrop.run", 4'h5, 1'b0, 1'b0, 2'b01);
    cyc(); cyc();
    reset = 1'b1;
    cyc(); expect_out("rstmid", 4'hF, 1'b0, 1'b0, 2'b00);
    reset = 1'b0;
    cyc(); expect_out("rstmid.run", 4'hF, 1'b0, 1'b0, 2'b01);
    cyc(); cyc();
    expect_out("rstmid.psc", 4'hF, 1'b0, 1'b0, 2'b01);
    cyc(); expect_out("rstmid.wrap", 4'h0, 1'b1, 1'b1, 2'b01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prescaled_updown_counter.md
# prescaled_updown_counter

- Parametrised successor to the team's fixed 4-bit down counter with derived slow clock.
- All logic runs on one clock, `mainClock`. A runtime-programmable prescaler produces a one-cycle step enable; no derived clock is generated.
- The counter counts up or down at a configurable width, with load, wrap or saturate modes, and terminal-count and step pulses.
- It sits between the board clock and display/LED logic as the general-purpose timed counter.

## Interface
- WIDTH, 4, counter width in bits (≥2).
- PRESCALE_BITS, 24, width of prescaler counter and `prescale` input (≥1).
- RESET_VALUE, {WIDTH{1'b1}}, value loaded into `count` by reset.

Ports:
- mainClock  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high; overrides every other input.
- enable  in  1  1 = counting permitted; 0 = idle, count held.
- up  in  1  direction: 1 = increment, 0 = decrement; sampled at each step.
- saturate  in  1  1 = stop at limit; 0 = wrap modulo 2^WIDTH.
- load  in  1  one-cycle load strobe.
- loadValue  in  WIDTH  value written to `count` on `load`.
- prescale  in  PRESCALE_BITS  a step occurs every prescale+1 cycles in RUN.
- count  out  WIDTH  current count, registered.
- tick  out  1  registered; high for exactly the cycle in which `count` shows a freshly stepped value.
- terminal  out  1  registered; high for one cycle when `count` wraps or reaches a limit.
- state  out  2  00 IDLE, 01 RUN, 10 HELD.

## Operation
- Reset (any edge where `reset`=1) sets:
  - `count`=RESET_VALUE, prescaler=0, `tick`=0, `terminal`=0, state=IDLE.
- Priority on each edge: reset > load > enable deassert > step.
- Load (reset=0, load=1):
  - `count`=loadValue, prescaler=0, `tick`=0, `terminal`=0.
  - State becomes RUN if `enable`=1, else IDLE. This also exits HELD.
- FSM:
  - IDLE: `enable`=1 → RUN with prescaler=0. Otherwise stay; count frozen.
  - RUN: `enable`=0 → IDLE, prescaler cleared.
  - RUN: when prescaler ≥ `prescale`, a step occurs and prescaler is cleared. Otherwise prescaler increments.
  - HELD: `enable`=0 → IDLE.
  - HELD: a direction moving away from the limit (`up`=0 at max, `up`=1 at 0) → RUN with prescaler=0.
  - HELD: `saturate`=0 → RUN with prescaler=0.
  - HELD: otherwise stay; prescaler idle, no ticks.
- Step, up:
  - count < max: count+1.
  - count = max, saturate=0: count=0, `terminal`=1.
  - count = max, saturate=1: count stays at max, no tick, state=HELD.
- Step, down: mirror image with 0 as the limit; wraps to max, or holds at 0 and enters HELD.
- Reaching the limit by a normal step asserts `terminal` and `tick`:
  - up, max−1 → max, saturate=1;
  - down, 1 → 0, saturate=1.
  - The next step attempt enters HELD with no tick.
- Width rules:
  - count arithmetic is modulo 2^WIDTH; max = 2^WIDTH−1.
  - prescaler compare is unsigned ≥, so lowering `prescale` below the current prescaler value forces a step on the next edge, never a 2^PRESCALE_BITS wait.

## Timing
- `tick`/`terminal` are registered alongside `count`; both deassert on the edge following the step.
- Step rate in RUN is one per (prescale+1) cycles; `prescale`=0 steps every cycle, and `tick` then stays high continuously.
- First step occurs prescale+1 edges after the edge that entered RUN.
- `load` takes effect on the same edge; `count`=loadValue is visible the following cycle.
- `enable` falling: count frozen from that edge; a step coinciding with deassert is suppressed.
- Reset mid-run: all outputs at reset values in the cycle after the reset edge; no partial step.
- `up`/`saturate` changes take effect at the next step; no glitch pulses.

## Test plan
- Reset: assert `reset` 2 cycles from arbitrary state → `count`=4'hF, `tick`=0, `terminal`=0, state=IDLE.
- Up wrap: WIDTH=4, prescale=2, up=1, saturate=0, load 4'hE, enable=1:
  - `count` reaches F at cycle 3, then 0 at cycle 6 with `terminal`=1 for one cycle;
  - `tick` every 3rd cycle.
- Down saturate: prescale=0, up=0, saturate=1, load 4'h2:
  - `count` 1, 0 (terminal=1 on the 0), then state=HELD with no further ticks;
  - setting up=1 → RUN, `count`=1 after one step.
- Load mid-run: prescale=5, load=1 with loadValue=4'h7 at prescaler=3 → `count`=7 next cycle, next step exactly 6 cycles later.
- Prescale shrink: prescale=100, wait until prescaler=50, set prescale=10 → step on the next edge, then every 11 cycles.
- Reset and enable-drop mid-run: drop `enable` on a step cycle → no step, state=IDLE; assert reset while RUN → `count`=F next cycle.
